// File: rtl/mezcladora_multi.sv
// Batch-mixer controller: sequences N_ING fill valves, waits for operator tokens,
// runs the mixer for MIX_CYCLES and drains. All outputs are decoded from registered state.
module mezcladora_multi #(
    parameter int unsigned N_ING        = 3,
    parameter int unsigned MIX_CYCLES   = 16,
    parameter int unsigned FILL_TIMEOUT = 64,
    parameter int unsigned TOK_REQ      = 2,
    localparam int unsigned SW = (N_ING > 1) ? $clog2(N_ING) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          in_i,
    input  logic          tok_i,
    input  logic          p1_i,
    input  logic          p2_i,
    output logic [N_ING-1:0] v_o,
    output logic          m_o,
    output logic          t_o,
    output logic          s_o,
    output logic          b_o,
    output logic          done_o,
    output logic          err_o,
    output logic [SW-1:0] step_o
);

    localparam int unsigned CntMax = (MIX_CYCLES > FILL_TIMEOUT) ? MIX_CYCLES : FILL_TIMEOUT;
    localparam int unsigned CW     = $clog2(CntMax) + 1;
    localparam int unsigned TW     = $clog2(TOK_REQ) + 1;

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StWaitTok,
        StMix,
        StDrain,
        StErr
    } state_e;

    state_e        state_q, state_d;
    logic [SW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] tok_cnt_q, tok_cnt_d;
    logic          done_q, done_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            cnt_q     <= '0;
            tok_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            tok_cnt_q <= tok_cnt_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        tok_cnt_d = tok_cnt_q;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_i) begin
                    state_d = StFill;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            end
            StFill: begin
                // Level-reached wins over a timeout landing on the same edge.
                if (p1_i) begin
                    cnt_d = '0;
                    if (idx_q == SW'(N_ING - 1)) begin
                        state_d   = StWaitTok;
                        tok_cnt_d = '0;
                    end else begin
                        idx_d = idx_q + SW'(1);
                    end
                end else if (cnt_q == CW'(FILL_TIMEOUT - 1)) begin
                    state_d = StErr;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StWaitTok: begin
                if (tok_i) begin
                    if (tok_cnt_q == TW'(TOK_REQ - 1)) begin
                        state_d = StMix;
                        cnt_d   = '0;
                    end else begin
                        tok_cnt_d = tok_cnt_q + TW'(1);
                    end
                end
            end
            StMix: begin
                if (cnt_q == CW'(MIX_CYCLES - 1)) begin
                    state_d = StDrain;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StDrain: begin
                if (!p2_i) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            StErr: begin
                if (tok_i) begin
                    state_d = StDrain;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        v_o    = '0;
        m_o    = 1'b0;
        t_o    = 1'b0;
        s_o    = 1'b0;
        b_o    = 1'b0;
        err_o  = 1'b0;
        step_o = '0;
        done_o = done_q;
        unique case (state_q)
            StFill: begin
                v_o    = N_ING'(1) << idx_q;
                t_o    = 1'b1;
                step_o = idx_q;
            end
            StMix: m_o = 1'b1;
            StDrain: begin
                s_o = 1'b1;
                b_o = 1'b1;
            end
            StErr: begin
                // Gravity drain only; pump stays off while the alarm is raised.
                err_o  = 1'b1;
                s_o    = 1'b1;
                step_o = idx_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mezcladora_multi.sv
// Directed bench for mezcladora_multi (N_ING=3, MIX_CYCLES=4, FILL_TIMEOUT=8, TOK_REQ=2).
module tb_mezcladora_multi;

    logic       clk, rst, in_s, tok, p1, p2;
    logic [2:0] v;
    logic       m, t, s, b, done, err;
    logic [1:0] step;
    logic [8:0] obs;
    logic [8:0] e;
    int         errors = 0;
    int         checks = 0;

    assign obs = {v, m, t, s, b, done, err};

    mezcladora_multi #(
        .N_ING(3),
        .MIX_CYCLES(4),
        .FILL_TIMEOUT(8),
        .TOK_REQ(2)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .in_i  (in_s),
        .tok_i (tok),
        .p1_i  (p1),
        .p2_i  (p2),
        .v_o   (v),
        .m_o   (m),
        .t_o   (t),
        .s_o   (s),
        .b_o   (b),
        .done_o(done),
        .err_o (err),
        .step_o(step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output vector in the same order as obs.
    function automatic logic [8:0] ex(input logic [2:0] ev, input logic em, input logic et,
                                      input logic es, input logic eb, input logic ed,
                                      input logic ee);
        return {ev, em, et, es, eb, ed, ee};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; in_s = 1'b0; tok = 1'b0; p1 = 1'b0; p2 = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0; in_s = 1'b0; tok = 1'b0; p1 = 1'b0; p2 = 1'b1;
        #1 rst = 1'b1;
        #1;
        checks++;
        if (obs !== 9'd0 || step !== 2'd0) begin
            errors++;
            $display("FAIL reset_async: got %b step %0d want 0 step 0", obs, step);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (obs !== 9'd0 || step !== 2'd0) begin
            errors++;
            $display("FAIL reset_idle: got %b step %0d want 0 step 0", obs, step);
        end
    endtask

    task automatic test_full_batch();
        int durs [3] = '{2, 3, 1};
        apply_reset();
        in_s = 1'b1;
        tick();
        in_s = 1'b0;
        for (int k = 0; k < 3; k++) begin
            for (int c = 1; c <= durs[k]; c++) begin
                e = ex(3'(1 << k), 0, 1, 0, 0, 0, 0);
                checks++;
                if (obs !== e || step !== 2'(k)) begin
                    errors++;
                    $display("FAIL batch_fill%0d_c%0d: got %b step %0d want %b step %0d",
                             k, c, obs, step, e, k);
                end
                p1 = (c == durs[k]);
                tick();
            end
        end
        p1 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (obs !== 9'd0) begin
                errors++;
                $display("FAIL batch_waittok_c%0d: got %b want 0", c, obs);
            end
            tok = (c == 0 || c == 2);
            tick();
            tok = 1'b0;
        end
        for (int c = 1; c <= 4; c++) begin
            e = ex(3'b000, 1, 0, 0, 0, 0, 0);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL batch_mix_c%0d: got %b want %b", c, obs, e);
            end
            tick();
        end
        for (int c = 1; c <= 5; c++) begin
            e = ex(3'b000, 0, 0, 1, 1, 0, 0);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL batch_drain_c%0d: got %b want %b", c, obs, e);
            end
            p2 = (c < 5);
            tick();
        end
        p2 = 1'b1;
        e = ex(3'b000, 0, 0, 0, 0, 1, 0);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL batch_done: got %b want %b", obs, e);
        end
        tick();
        checks++;
        if (obs !== 9'd0) begin
            errors++;
            $display("FAIL batch_idle_after: got %b want 0", obs);
        end
    endtask

    task automatic test_fill_timeout();
        apply_reset();
        in_s = 1'b1;
        tick();
        in_s = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            e = ex(3'b001, 0, 1, 0, 0, 0, 0);
            checks++;
            if (obs !== e || step !== 2'd0) begin
                errors++;
                $display("FAIL timeout_fill_c%0d: got %b step %0d want %b step 0",
                         c, obs, step, e);
            end
            tick();
        end
        for (int c = 0; c < 2; c++) begin
            e = ex(3'b000, 0, 0, 1, 0, 0, 1);
            checks++;
            if (obs !== e || step !== 2'd0) begin
                errors++;
                $display("FAIL timeout_err_c%0d: got %b step %0d want %b step 0",
                         c, obs, step, e);
            end
            tok = (c == 1);
            tick();
        end
        tok = 1'b0;
        e = ex(3'b000, 0, 0, 1, 1, 0, 0);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL timeout_drain: got %b want %b", obs, e);
        end
        p2 = 1'b0;
        tick();
        p2 = 1'b1;
        e = ex(3'b000, 0, 0, 0, 0, 1, 0);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL timeout_done: got %b want %b", obs, e);
        end
        // Back-to-back: start request during the DONE cycle.
        in_s = 1'b1;
        tick();
        in_s = 1'b0;
        e = ex(3'b001, 0, 1, 0, 0, 0, 0);
        checks++;
        if (obs !== e || step !== 2'd0) begin
            errors++;
            $display("FAIL back_to_back: got %b step %0d want %b step 0", obs, step, e);
        end
    endtask

    task automatic test_boundary_and_tokens();
        apply_reset();
        in_s = 1'b1;
        tick();
        in_s = 1'b0;
        p1 = 1'b1;
        tick();
        for (int c = 1; c <= 8; c++) begin
            e = ex(3'b010, 0, 1, 0, 0, 0, 0);
            checks++;
            if (obs !== e || step !== 2'd1) begin
                errors++;
                $display("FAIL boundary_v1_c%0d: got %b step %0d want %b step 1",
                         c, obs, step, e);
            end
            p1 = (c == 8);
            tick();
        end
        e = ex(3'b100, 0, 1, 0, 0, 0, 0);
        checks++;
        if (obs !== e || step !== 2'd2) begin
            errors++;
            $display("FAIL boundary_v2: got %b step %0d want %b step 2", obs, step, e);
        end
        p1 = 1'b1;
        tick();
        p1 = 1'b0;
        tok = 1'b1;
        tick();
        checks++;
        if (obs !== 9'd0) begin
            errors++;
            $display("FAIL tok_first_cycle: got %b want 0", obs);
        end
        tick();
        e = ex(3'b000, 1, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL tok_mix_entry: got %b want %b", obs, e);
        end
        tick();
        tok = 1'b0;
        for (int c = 2; c <= 4; c++) begin
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL mix_ignore_c%0d: got %b want %b", c, obs, e);
            end
            in_s = (c == 2);
            tick();
        end
        in_s = 1'b0;
        e = ex(3'b000, 0, 0, 1, 1, 0, 0);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL mix_len: got %b want %b", obs, e);
        end
    endtask

    task automatic test_p1_held_and_async_reset();
        apply_reset();
        in_s = 1'b1;
        tick();
        in_s = 1'b0;
        p1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            e = ex(3'(1 << k), 0, 1, 0, 0, 0, 0);
            checks++;
            if (obs !== e || step !== 2'(k)) begin
                errors++;
                $display("FAIL p1_held_%0d: got %b step %0d want %b step %0d",
                         k, obs, step, e, k);
            end
            tok = (k < 2);
            tick();
        end
        p1 = 1'b0;
        tok = 1'b0;
        tick();
        checks++;
        if (obs !== 9'd0) begin
            errors++;
            $display("FAIL waittok_hold: got %b want 0", obs);
        end
        tok = 1'b1;
        tick();
        tok = 1'b0;
        checks++;
        if (obs !== 9'd0) begin
            errors++;
            $display("FAIL waittok_one_tok: got %b want 0", obs);
        end
        tok = 1'b1;
        tick();
        tok = 1'b0;
        tick();
        e = ex(3'b000, 1, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL async_pre_mix: got %b want %b", obs, e);
        end
        #3 rst = 1'b1;
        #1;
        checks++;
        if (obs !== 9'd0 || step !== 2'd0) begin
            errors++;
            $display("FAIL async_reset: got %b step %0d want 0 step 0", obs, step);
        end
        #2 rst = 1'b0;
        tick();
        in_s = 1'b1;
        tick();
        in_s = 1'b0;
        e = ex(3'b001, 0, 1, 0, 0, 0, 0);
        checks++;
        if (obs !== e || step !== 2'd0) begin
            errors++;
            $display("FAIL async_restart: got %b step %0d want %b step 0", obs, step, e);
        end
    endtask

    initial begin
        test_reset();
        test_full_batch();
        test_fill_timeout();
        test_boundary_and_tokens();
        test_p1_held_and_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
